// File: rtl/median3x3_stream_if.sv
// Pixel stream bundle for median3x3_stream: valid/ready input side, frame-marked output side.
// The master drives pixels and frame settings; the slave (the filter) answers with filtered pixels.
interface median3x3_stream_if #(
  parameter int DW = 8
);
  logic [DW-1:0] pixel_in;
  logic          pixel_in_vld;
  logic          pixel_in_rdy;
  logic          border_mode;
  logic          bypass;
  logic [DW-1:0] pixel_out;
  logic          vld;
  logic          sof;
  logic          eof;

  modport master (
    output pixel_in, pixel_in_vld, border_mode, bypass,
    input  pixel_in_rdy, pixel_out, vld, sof, eof
  );

  modport slave (
    input  pixel_in, pixel_in_vld, border_mode, bypass,
    output pixel_in_rdy, pixel_out, vld, sof, eof
  );
endinterface

// File: rtl/median3x3_stream.sv
// Streaming 3x3 median filter for raster-scan frames: two line buffers feed a 3x3 window,
// border taps are patched per frame mode, then a 3-stage min/max network picks the median.
module median3x3_stream #(
  parameter int DW = 8,
  parameter int W  = 430,
  parameter int H  = 554
) (
  input logic clk,
  input logic rst,
  median3x3_stream_if.slave io
);
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H + 2);

  typedef enum logic {RUN, FLUSH} state_t;
  state_t state_reg, state_next;

  logic [CW-1:0] in_col_reg, out_col_reg, col_next;
  logic [RW-1:0] in_row_reg, out_row_reg;
  logic          border_reg, bypass_reg;
  logic          step, launch, last_in, last_flush;
  logic [DW-1:0] pix;

  function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? a : b;
  endfunction
  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a < b) ? b : a;
  endfunction
  function automatic logic [DW-1:0] med3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (step && last_in) state_next = FLUSH;
      FLUSH:   if (last_flush) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    io.pixel_in_rdy = (state_reg == RUN) && !rst;
  end

  // A flush cycle is a step with a virtual zero pixel from rows H and H+1
  assign step       = (state_reg == FLUSH) || (io.pixel_in_vld && io.pixel_in_rdy);
  assign last_in    = (in_row_reg == RW'(H - 1)) && (in_col_reg == CW'(W - 1));
  assign last_flush = (in_row_reg == RW'(H + 1));
  assign launch     = (in_row_reg >= RW'(2)) || ((in_row_reg == RW'(1)) && (in_col_reg != '0));
  assign pix        = (state_reg == RUN) ? io.pixel_in : '0;
  assign col_next   = (in_col_reg == CW'(W - 1)) ? '0 : in_col_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_col_reg  <= '0;
      in_row_reg  <= '0;
      out_col_reg <= '0;
      out_row_reg <= '0;
      border_reg  <= 1'b0;
      bypass_reg  <= 1'b0;
    end else if (step) begin
      if (state_reg == RUN && in_row_reg == '0 && in_col_reg == '0) begin
        border_reg <= io.border_mode;
        bypass_reg <= io.bypass;
      end
      if (last_flush) begin
        in_col_reg <= '0;
        in_row_reg <= '0;
      end else begin
        in_col_reg <= col_next;
        if (in_col_reg == CW'(W - 1)) in_row_reg <= in_row_reg + 1'b1;
      end
      if (launch) begin
        if (out_col_reg == CW'(W - 1)) begin
          out_col_reg <= '0;
          out_row_reg <= (out_row_reg == RW'(H - 1)) ? '0 : out_row_reg + 1'b1;
        end else begin
          out_col_reg <= out_col_reg + 1'b1;
        end
      end
    end
  end

  // Line buffers read one column ahead so the registered read lands in time for the next step
  logic [DW-1:0] lb1_mem [W];
  logic [DW-1:0] lb2_mem [W];
  logic [DW-1:0] rd1_reg, rd2_reg;

  always_ff @(posedge clk) begin
    if (step) begin
      lb1_mem[in_col_reg] <= pix;
      lb2_mem[in_col_reg] <= rd1_reg;
      rd1_reg             <= lb1_mem[col_next];
      rd2_reg             <= lb2_mem[col_next];
    end
  end

  // win_reg[col][row]: col 2 is the newest column, row 2 the newest row
  logic [DW-1:0] win_reg [3][3];
  logic          l_vld_reg, l_border_reg, l_bypass_reg;
  logic [CW-1:0] l_col_reg;
  logic [RW-1:0] l_row_reg;

  always_ff @(posedge clk) begin
    if (step) begin
      win_reg[0]    <= win_reg[1];
      win_reg[1]    <= win_reg[2];
      win_reg[2][0] <= rd2_reg;
      win_reg[2][1] <= rd1_reg;
      win_reg[2][2] <= pix;
      l_col_reg     <= out_col_reg;
      l_row_reg     <= out_row_reg;
      l_border_reg  <= border_reg;
      l_bypass_reg  <= bypass_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) l_vld_reg <= 1'b0;
    else     l_vld_reg <= step && launch;
  end

  // Out-of-frame taps: replicate mode borrows the centre row/column, zero mode forces 0
  logic [9*DW-1:0] tap_flat;
  logic [2:0][DW-1:0] row_lo, row_md, row_hi;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_tap
      localparam logic [1:0] TR = 2'(gi / 3);
      localparam logic [1:0] TC = 2'(gi % 3);
      logic row_out, col_out;
      assign row_out = (TR == 2'd0 && l_row_reg == '0) || (TR == 2'd2 && l_row_reg == RW'(H - 1));
      assign col_out = (TC == 2'd0 && l_col_reg == '0) || (TC == 2'd2 && l_col_reg == CW'(W - 1));
      assign tap_flat[gi*DW +: DW] = l_border_reg ? ((row_out || col_out) ? '0 : win_reg[TC][TR])
                                                  : win_reg[col_out ? 2'd1 : TC][row_out ? 2'd1 : TR];
    end
    for (gi = 0; gi < 3; gi++) begin : g_row_sort
      logic [DW-1:0] a, b, c;
      assign a = tap_flat[(gi*3+0)*DW +: DW];
      assign b = tap_flat[(gi*3+1)*DW +: DW];
      assign c = tap_flat[(gi*3+2)*DW +: DW];
      assign row_lo[gi] = min2(min2(a, b), c);
      assign row_md[gi] = med3(a, b, c);
      assign row_hi[gi] = max2(max2(a, b), c);
    end
  endgenerate

  logic [2:0][DW-1:0] s1_lo, s1_md, s1_hi;
  logic [DW-1:0] s1_ctr, s2_lo, s2_md, s2_hi, s2_ctr, s3_val;
  logic s1_vld, s1_sof, s1_eof, s1_byp, s2_vld, s2_sof, s2_eof, s2_byp, s3_vld, s3_sof, s3_eof;

  // Median of 9 = med3(max of row minima, median of row medians, min of row maxima)
  always_ff @(posedge clk) begin
    s1_lo  <= row_lo;
    s1_md  <= row_md;
    s1_hi  <= row_hi;
    s1_ctr <= win_reg[1][1];
    s1_byp <= l_bypass_reg;
    s1_sof <= (l_row_reg == '0) && (l_col_reg == '0);
    s1_eof <= (l_row_reg == RW'(H - 1)) && (l_col_reg == CW'(W - 1));
    s2_lo  <= max2(max2(s1_lo[0], s1_lo[1]), s1_lo[2]);
    s2_md  <= med3(s1_md[0], s1_md[1], s1_md[2]);
    s2_hi  <= min2(min2(s1_hi[0], s1_hi[1]), s1_hi[2]);
    s2_ctr <= s1_ctr;
    s2_byp <= s1_byp;
    s2_sof <= s1_sof;
    s2_eof <= s1_eof;
    s3_val <= s2_byp ? s2_ctr : med3(s2_lo, s2_md, s2_hi);
    s3_sof <= s2_sof;
    s3_eof <= s2_eof;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld       <= 1'b0;
      s2_vld       <= 1'b0;
      s3_vld       <= 1'b0;
      io.pixel_out <= '0;
      io.vld       <= 1'b0;
      io.sof       <= 1'b0;
      io.eof       <= 1'b0;
    end else begin
      s1_vld <= l_vld_reg;
      s2_vld <= s1_vld;
      s3_vld <= s2_vld;
      io.vld <= s3_vld;
      io.sof <= s3_vld && s3_sof;
      io.eof <= s3_vld && s3_eof;
      if (s3_vld) io.pixel_out <= s3_val;
    end
  end
endmodule

// File: tb/tb_median3x3_stream.sv
// Scoreboard bench for median3x3_stream: each frame's expected outputs come from a direct
// window/sort model and are queued; a negedge monitor pops and compares every output pixel.
module tb_median3x3_stream;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;

  typedef struct packed {
    logic [DW-1:0] pix;
    logic          sof;
    logic          eof;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;
  int   first_acc = -1;
  int   first_out = -1;
  int   frame_pix [N];
  exp_t exp_q [$];
  exp_t mon_e;

  median3x3_stream_if #(.DW(DW)) io ();
  median3x3_stream #(.DW(DW), .W(W), .H(H)) dut (.clk(clk), .rst(rst), .io(io));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end else begin
      $display("chk %s = %0d ok", name, got);
    end
  endtask

  // Tap (r,c) of the frame; out-of-frame taps are zero or clamped to the nearest edge pixel
  function automatic int tap_model(input int r, input int c, input bit bm);
    if (r < 0 || r >= H || c < 0 || c >= W) begin
      if (bm) return 0;
      r = (r < 0) ? 0 : ((r >= H) ? H - 1 : r);
      c = (c < 0) ? 0 : ((c >= W) ? W - 1 : c);
    end
    return frame_pix[r*W + c];
  endfunction

  task automatic push_expected(input bit bm, input bit byp);
    int v [9];
    int t;
    exp_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        for (int i = 0; i < 9; i++) v[i] = tap_model(r + i / 3 - 1, c + i % 3 - 1, bm);
        for (int a = 0; a < 8; a++)
          for (int b = 0; b < 8 - a; b++)
            if (v[b] > v[b+1]) begin t = v[b]; v[b] = v[b+1]; v[b+1] = t; end
        e.pix = DW'(byp ? frame_pix[r*W + c] : v[4]);
        e.sof = (r == 0 && c == 0);
        e.eof = (r == H - 1 && c == W - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < N; i++) frame_pix[i] = v;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) frame_pix[i] = int'($urandom_range(0, 255));
  endtask

  // gap_mode 0: continuous, 1: vld pattern 1-0-0, 2: random vld
  task automatic send_frame(input bit bm, input bit byp, input int gap_mode, input int npix);
    int idx = 0;
    int t = 0;
    bit go, acc;
    if (npix == N) push_expected(bm, byp);
    while (idx < npix) begin
      @(negedge clk);
      case (gap_mode)
        0:       go = 1'b1;
        1:       go = (t % 3 == 0);
        default: go = 1'($urandom_range(0, 1));
      endcase
      io.pixel_in_vld = go;
      io.pixel_in     = DW'(frame_pix[idx]);
      io.border_mode  = (idx == 0) ? bm  : 1'($urandom_range(0, 1));
      io.bypass       = (idx == 0) ? byp : 1'($urandom_range(0, 1));
      acc = go && io.pixel_in_rdy;
      if (acc && idx == 0 && first_acc < 0) first_acc = cyc + 1;
      @(posedge clk);
      if (acc) idx++;
      t++;
      if (t > 3 * N + 50) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: got %0d pixels accepted, required %0d", idx, npix);
        break;
      end
    end
    @(negedge clk);
    io.pixel_in_vld = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && io.vld) begin
      n_out++;
      if (first_out < 0) first_out = cyc;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL stray_out: got pix=%0d sof=%0b eof=%0b, required no output",
                 io.pixel_out, io.sof, io.eof);
      end else begin
        mon_e = exp_q.pop_front();
        if (io.pixel_out !== mon_e.pix || io.sof !== mon_e.sof || io.eof !== mon_e.eof) begin
          n_bad++;
          $display("FAIL out_%0d: got pix=%0d sof=%0b eof=%0b, required pix=%0d sof=%0b eof=%0b",
                   n_out, io.pixel_out, io.sof, io.eof, mon_e.pix, mon_e.sof, mon_e.eof);
        end else begin
          $display("out %0d pix=%0d sof=%0b eof=%0b ok", n_out, io.pixel_out, io.sof, io.eof);
        end
      end
    end else if (!rst && (io.sof || io.eof)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL marker_without_vld: got sof=%0b eof=%0b, required 0 0", io.sof, io.eof);
    end
  end

  initial begin
    int cnt;
    io.pixel_in     = '0;
    io.pixel_in_vld = 1'b0;
    io.border_mode  = 1'b0;
    io.bypass       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", int'({io.pixel_out, io.vld, io.sof, io.eof}), 0);
    check("rst_rdy", int'(io.pixel_in_rdy), 0);
    rst = 1'b0;
    #1;
    check("rdy_after_rst", int'(io.pixel_in_rdy), 1);

    fill_const(50);
    send_frame(1'b0, 1'b0, 0, N);
    cnt = 0;
    while (io.pixel_in_rdy == 1'b0 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("rdy_low_cycles", cnt, W + 1);
    check("first_latency", first_out - first_acc, W + 1 + 4);

    fill_const(0);
    frame_pix[1*W + 1] = 255;
    send_frame(1'b0, 1'b0, 0, N);

    fill_const(0);
    frame_pix[0] = 255;
    frame_pix[1] = 255;
    frame_pix[W] = 255;
    send_frame(1'b0, 1'b0, 0, N);

    fill_const(100);
    send_frame(1'b1, 1'b0, 0, N);

    fill_random();
    send_frame(1'b0, 1'b0, 1, N);
    fill_random();
    send_frame(1'b1, 1'b0, 2, N);

    for (int i = 0; i < N; i++) frame_pix[i] = i;
    send_frame(1'b0, 1'b1, 2, N);

    // Abandon a frame after 7 pixels; nothing from it may emerge
    fill_random();
    send_frame(1'b0, 1'b0, 0, 7);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", int'({io.pixel_out, io.vld, io.sof, io.eof}), 0);
    check("midrst_rdy", int'(io.pixel_in_rdy), 0);
    rst = 1'b0;

    fill_const(20);
    send_frame(1'b0, 1'b0, 0, N);
    fill_random();
    send_frame(1'($urandom_range(0, 1)), 1'b0, 0, N);
    fill_random();
    send_frame(1'($urandom_range(0, 1)), 1'b0, 0, N);

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 60) begin
      cnt++;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("leftover_expected", exp_q.size(), 0);
    check("total_outputs", n_out, 10 * N);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
